// File: rtl/sdf_pkg.sv
// sdf_pkg: shared complex type, rotation tags, clog2 and butterfly reduction for SDF FFT stages
`ifndef SDF_CPLX_T
`define SDF_CPLX_T(W) struct packed { logic signed [(W)-1:0] re; logic signed [(W)-1:0] im; }
`endif

package sdf_pkg;

    localparam int MAXW = 32;
    localparam logic ROT_NONE = 1'b0;
    localparam logic ROT_NJ = 1'b1;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++)
            if ((1 << i) < v) r = i + 1;
        return r;
    endfunction

    // Reduce a butterfly sum to w bits: halve (optionally rounding half-up), or saturate/wrap.
    function automatic logic signed [MAXW-1:0] bf_reduce(
        input logic signed [MAXW:0] sum,
        input int                   w,
        input logic                 scale,
        input logic                 rh,
        input logic                 sat
    );
        logic signed [MAXW:0] one, hi, lo, r;
        one = (MAXW + 1)'(1);
        hi = (one <<< (w - 1)) - one;
        lo = -hi - one;
        r = scale ? (sum + (rh ? one : '0)) >>> 1 : sum;
        if (sat && !scale) r = (r > hi) ? hi : ((r < lo) ? lo : r);
        return MAXW'(r);
    endfunction

endpackage

// File: rtl/sdf_unit_r2p_butterfly.sv
// sdf_butterfly: combinational radix-2 add/sub with scaling, rounding and optional saturation (SDF_SAT_EN)
module sdf_butterfly
    import sdf_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SCALE = 0,
    parameter int BF_RH = 0
) (
    input  logic              en,
    input  `SDF_CPLX_T(WIDTH) x0,
    input  `SDF_CPLX_T(WIDTH) x1,
    output `SDF_CPLX_T(WIDTH) y0,
    output `SDF_CPLX_T(WIDTH) y1
);

`ifdef SDF_SAT_EN
    localparam logic SAT = 1'b1;
`else
    localparam logic SAT = 1'b0;
`endif

    logic signed [MAXW:0] a_re, a_im, b_re, b_im;

    // Operands are zeroed outside the second half so nothing undefined leaks into the sums.
    always_comb begin
        a_re = en ? (MAXW + 1)'(x0.re) : '0;
        a_im = en ? (MAXW + 1)'(x0.im) : '0;
        b_re = en ? (MAXW + 1)'(x1.re) : '0;
        b_im = en ? (MAXW + 1)'(x1.im) : '0;
        y0.re = WIDTH'(bf_reduce(a_re + b_re, WIDTH, SCALE != 0, BF_RH != 0, SAT));
        y0.im = WIDTH'(bf_reduce(a_im + b_im, WIDTH, SCALE != 0, BF_RH != 0, SAT));
        y1.re = WIDTH'(bf_reduce(a_re - b_re, WIDTH, SCALE != 0, BF_RH != 0, SAT));
        y1.im = WIDTH'(bf_reduce(a_im - b_im, WIDTH, SCALE != 0, BF_RH != 0, SAT));
    end

endmodule

// File: rtl/sdf_unit_r2p.sv
// sdf_unit_r2p: radix-2 single-path delay-feedback DIF FFT stage; SDF_SAT_EN selects saturating sums
module sdf_unit_r2p
    import sdf_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 1,
    parameter int BF_RH = 0,
    parameter int SCALE = 0,
    parameter int TW_NJ = 0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             di_en,
    input  logic [WIDTH-1:0] di_re,
    input  logic [WIDTH-1:0] di_im,
    output logic             do_en,
    output logic [WIDTH-1:0] do_re,
    output logic [WIDTH-1:0] do_im
);

    localparam int CW = clog2(DEPTH) + 1;
    localparam int QB = (CW > 1) ? CW - 2 : 0;
    localparam logic NJ = (TW_NJ != 0) && (DEPTH > 1);

    typedef `SDF_CPLX_T(WIDTH) cplx_t;
    // Each buffered word carries a tag saying whether it leaves rotated by -j.
    typedef struct packed {
        logic  rot;
        cplx_t d;
    } word_t;

    logic [CW-1:0] cnt;
    logic          bf_en, rot_now;
    logic [DEPTH:0] en_sr;
    cplx_t         x1, y0, y1, tail, sel;
    word_t         buf_in, buf_out;

    assign bf_en = cnt[CW-1];
    assign x1 = '{re: di_re, im: di_im};
    assign rot_now = !bf_en && (buf_out.rot == ROT_NJ);
    assign do_en = en_sr[DEPTH];

    // Frame position: counts valid samples, any gap in di_en restarts the frame.
    always_ff @(posedge clock or posedge reset)
        if (reset) cnt <= '0;
        else cnt <= di_en ? cnt + 1'b1 : '0;

    // Output valid is the input valid delayed by the buffer depth plus the output register.
    always_ff @(posedge clock or posedge reset)
        if (reset) en_sr <= '0;
        else en_sr <= {en_sr[DEPTH-1:0], di_en};

    sdf_butterfly #(.WIDTH(WIDTH), .SCALE(SCALE), .BF_RH(BF_RH)) u_bf (
        .en(bf_en),
        .x0(buf_out.d),
        .x1(x1),
        .y0(y0),
        .y1(y1)
    );

    // First half feeds the buffer and drains the previous y1; second half feeds back y1 and emits y0.
    always_comb begin
        buf_in.rot = (bf_en && NJ && cnt[QB]) ? ROT_NJ : ROT_NONE;
        buf_in.d = bf_en ? y1 : x1;
        tail.re = rot_now ? buf_out.d.im : buf_out.d.re;
        tail.im = rot_now ? -buf_out.d.re : buf_out.d.im;
        sel = bf_en ? y0 : tail;
    end

    // Registered data output; data path carries no reset.
    always_ff @(posedge clock) begin
        do_re <= sel.re;
        do_im <= sel.im;
    end

    generate
        if (DEPTH < 64) begin : g_sr
            word_t sr [DEPTH];
            // Delay line advances every clock so the last y1 half flushes after di_en falls.
            always_ff @(posedge clock) begin
                sr[0] <= buf_in;
                for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
            end
            assign buf_out = sr[DEPTH-1];
        end else begin : g_ram
            word_t mem [DEPTH];
            logic [CW-2:0] ptr;
            // Circular pointer makes the memory behave as a DEPTH-word delay line.
            always_ff @(posedge clock or posedge reset)
                if (reset) ptr <= '0;
                else ptr <= ptr + 1'b1;
            // Read-before-write at the same slot returns the word stored DEPTH clocks ago.
            always_ff @(posedge clock)
                mem[ptr] <= buf_in;
            assign buf_out = mem[ptr];
        end
    endgenerate

endmodule

// File: tb/tb_sdf_unit_r2p.sv
// tb_sdf_unit_r2p: directed and random frames on several configurations, checked against a frame-level model
`timescale 1ns/1ps
module tb_sdf_unit_r2p;

    localparam int NU = 5;
    localparam int DEP [NU] = '{1, 4, 4, 8, 64};
    localparam int SCL [NU] = '{0, 1, 0, 0, 1};
    localparam int RH  [NU] = '{0, 1, 0, 0, 0};
    localparam int NJ  [NU] = '{0, 0, 1, 0, 1};

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic di_en [NU];
    logic [15:0] di_re [NU];
    logic [15:0] di_im [NU];
    wire do_en [NU];
    wire [15:0] do_re [NU];
    wire [15:0] do_im [NU];

    int tests = 0;
    int fails = 0;
    logic [15:0] xr [$];
    logic [15:0] xi [$];
    logic [15:0] er [$];
    logic [15:0] ei [$];

    always #5 clock = ~clock;

    for (genvar g = 0; g < NU; g++) begin : g_dut
        sdf_unit_r2p #(
            .WIDTH(16), .DEPTH(DEP[g]), .BF_RH(RH[g]), .SCALE(SCL[g]), .TW_NJ(NJ[g])
        ) dut (
            .clock(clock),
            .reset(reset),
            .di_en(di_en[g]),
            .di_re(di_re[g]),
            .di_im(di_im[g]),
            .do_en(do_en[g]),
            .do_re(do_re[g]),
            .do_im(do_im[g])
        );
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] want);
        tests++;
        assert (obs === want) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, want);
        end
    endtask

    function automatic int sx(input logic [15:0] v);
        return int'($signed(v));
    endfunction

    // Exact arithmetic result reduced the way the stage's configuration demands.
    function automatic logic [15:0] red(input int s, input int u);
        int r = s;
        if (SCL[u] != 0) r = (s + RH[u]) >>> 1;
`ifdef SDF_SAT_EN
        else r = (r > 32767) ? 32767 : ((r < -32768) ? -32768 : r);
`endif
        return 16'(r);
    endfunction

    // Per frame: D sums, then D differences, the last D/2 of them multiplied by -j when enabled.
    task automatic model(input int u);
        int d = DEP[u];
        er.delete();
        ei.delete();
        for (int b = 0; b < xr.size(); b += 2 * d) begin
            for (int k = 0; k < d; k++) begin
                er.push_back(red(sx(xr[b+k]) + sx(xr[b+k+d]), u));
                ei.push_back(red(sx(xi[b+k]) + sx(xi[b+k+d]), u));
            end
            for (int k = 0; k < d; k++) begin
                logic [15:0] r = red(sx(xr[b+k]) - sx(xr[b+k+d]), u);
                logic [15:0] i = red(sx(xi[b+k]) - sx(xi[b+k+d]), u);
                logic rot = (NJ[u] != 0) && (d > 1) && (k >= d / 2);
                er.push_back(rot ? i : r);
                ei.push_back(rot ? 16'(-sx(r)) : i);
            end
        end
    endtask

    task automatic fill_rand(input int u, input int nf);
        xr.delete();
        xi.delete();
        repeat (nf * 2 * DEP[u]) begin
            xr.push_back(16'($urandom));
            xi.push_back(16'($urandom));
        end
    endtask

    // Streams xr/xi back to back into unit u and checks every output cycle; optional reset at abort_at.
    task automatic play(input int u, input int abort_at);
        int d = DEP[u];
        int n = xr.size();
        model(u);
        for (int t = 0; t < n + d + 3; t++) begin
            if (t == abort_at) begin
                reset = 1'b1;
                di_en[u] = 1'b0;
                #1;
                chk($sformatf("u%0d reset_async do_en", u), 16'(do_en[u]), 16'd0);
                @(posedge clock);
                #1;
                chk($sformatf("u%0d reset_next do_en", u), 16'(do_en[u]), 16'd0);
                reset = 1'b0;
                return;
            end
            di_en[u] = t < n;
            di_re[u] = (t < n) ? xr[t] : 16'($urandom);
            di_im[u] = (t < n) ? xi[t] : 16'($urandom);
            @(posedge clock);
            #1;
            chk($sformatf("u%0d t%0d do_en", u, t), 16'(do_en[u]), 16'(t >= d && t < d + n));
            if (t >= d && t < d + n) begin
                chk($sformatf("u%0d t%0d do_re", u, t), do_re[u], er[t-d]);
                chk($sformatf("u%0d t%0d do_im", u, t), do_im[u], ei[t-d]);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < NU; i++) begin
            di_en[i] = 1'b0;
            di_re[i] = '0;
            di_im[i] = '0;
        end
        repeat (3) @(posedge clock);
        #1;
        for (int u = 0; u < NU; u++) chk($sformatf("u%0d reset do_en", u), 16'(do_en[u]), 16'd0);
        reset = 1'b0;

        xr = '{16'd1, 16'd2};
        xi = '{16'd0, 16'd0};
        play(0, -1);
        fill_rand(0, 4);
        play(0, -1);

        xr = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8};
        xi = '{16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0};
        play(1, -1);
        fill_rand(1, 3);
        play(1, -1);

        xr = '{16'd0, 16'd0, 16'd0, 16'd0, 16'd1, 16'd1, 16'd1, 16'd1};
        xi = '{16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0};
        play(2, -1);

        xr.delete();
        xi.delete();
        repeat (16) begin
            xr.push_back(16'h7000);
            xi.push_back(16'h7000);
        end
        play(3, -1);
        fill_rand(3, 3);
        play(3, -1);

        fill_rand(2, 2);
        play(2, 2 * DEP[2] + 3);
        fill_rand(2, 2);
        play(2, -1);

        fill_rand(4, 2);
        play(4, -1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
